q2_panel: RTL and testbench

Front-panel sequencer for the q2 datapath. It synchronizes and debounces the raw panel switches: the 12-bit data switches plus the deposit, increment-P, start and stop buttons. It turns button presses into clean, fixed-width deposit and increment-P pulses for the slices, and owns the run/halt state that gates the clock generator. It sits between the physical panel and the `dep_sw`/`incp_sw`/`start_sw`/`stop_sw`/`sw` inputs of the top level.

---
 rtl/q2_panel.sv | 100 ++++++++++
 tb/tb_q2_panel.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_panel.sv
// q2_panel: front-panel synchronizer/debouncer and run/deposit/increment-P sequencer; define Q2_PANEL_AUTOINC_EN to chain each deposit into an increment-P pulse.
module q2_panel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw_raw,
  input  logic        dep_raw,
  input  logic        incp_raw,
  input  logic        start_raw,
  input  logic        stop_raw,
  input  logic        halt,
  output logic [11:0] sw,
  output logic        dep,
  output logic        incp,
  output logic        run,
  output logic        busy
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, RUNNING, DEP, DEP_GAP, INCP, INCP_GAP} state_t;
`ifdef Q2_PANEL_AUTOINC_EN
  localparam state_t GAP_NEXT = INCP;
`else
  localparam state_t GAP_NEXT = IDLE;
`endif
  state_t state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [11:0] sw_s1, sw_s2;
  logic [3:0] b_raw, b_s1, b_s2, lvl, lvl_d, press;
  logic [DW-1:0] dcnt [4];
  logic halt_q, halt_d, halt_ev;
  logic dep_ev, incp_ev, start_ev, stop_ev;
  assign b_raw = {stop_raw, start_raw, incp_raw, dep_raw};
  assign {stop_ev, start_ev, incp_ev, dep_ev} = press;
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      b_s1 <= '0;
      b_s2 <= '0;
      lvl <= '0;
      lvl_d <= '0;
      press <= '0;
      halt_q <= 1'b0;
      halt_d <= 1'b0;
      halt_ev <= 1'b0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      sw_s1 <= sw_raw;
      sw_s2 <= sw_s1;
      b_s1 <= b_raw;
      b_s2 <= b_s1;
      lvl_d <= lvl;
      press <= lvl & ~lvl_d;
      halt_q <= halt;
      halt_d <= halt_q;
      halt_ev <= halt_q & ~halt_d;
      // Any cycle agreeing with the debounced level restarts the stability count
      for (int i = 0; i < 4; i++) begin
        if (b_s2[i] == lvl[i]) dcnt[i] <= '0;
        else if (dcnt[i] == D_LAST) begin
          lvl[i] <= ~lvl[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcnt <= '0;
      sw <= '0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      if (state == IDLE) sw <= sw_s2;
    end
  end
  always_comb begin
    state_n = state;
    pcnt_n = '0;
    case (state)
      IDLE: state_n = stop_ev ? IDLE : start_ev ? RUNNING : dep_ev ? DEP : incp_ev ? INCP : IDLE;
      RUNNING: state_n = (stop_ev | halt_ev) ? IDLE : RUNNING;
      default: begin
        pcnt_n = (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
        if (pcnt == P_LAST)
          state_n = state == DEP ? DEP_GAP : state == INCP ? INCP_GAP : state == DEP_GAP ? GAP_NEXT : IDLE;
      end
    endcase
  end
  assign run = state == RUNNING;
  assign dep = state == DEP;
  assign incp = state == INCP;
  assign busy = !(state == IDLE || state == RUNNING);
endmodule

// File: tb/tb_q2_panel.sv
// tb_q2_panel: scoreboard bench for q2_panel; pulse expectations are queued at stimulus time and popped as pulses end.
module tb_q2_panel;
  logic clk = 0, rst = 1;
  logic [11:0] sw_raw = '0;
  logic dep_raw = 0, incp_raw = 0, start_raw = 0, stop_raw = 0, halt = 0;
  logic [11:0] sw;
  logic dep, incp, run, busy;
  int tests = 0, fails = 0, cyc = 0;
  bit chk_en = 0;
  typedef struct {int kind; int start; int width; logic [11:0] sw;} pulse_t;
  pulse_t sb[$];
`ifdef Q2_PANEL_AUTOINC_EN
  localparam bit AUTO = 1;
`else
  localparam bit AUTO = 0;
`endif
  q2_panel dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .dep_raw(dep_raw), .incp_raw(incp_raw),
    .start_raw(start_raw), .stop_raw(stop_raw), .halt(halt),
    .sw(sw), .dep(dep), .incp(incp), .run(run), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bit [1:0] prv;
  int st [2];
  logic [11:0] swst [2];
  always @(negedge clk) begin
    logic [1:0] cur;
    pulse_t e;
    cur = {incp, dep};
    if (chk_en) begin
      tests++;
      if ((dep & incp) === 1'b1 || (run & (dep | incp)) === 1'b1) begin
        fails++;
        $display("FAIL exclusive cyc=%0d dep=%b incp=%b run=%b required at most one high", cyc, dep, incp, run);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (cur[k] === 1'b1 && !prv[k]) begin
        st[k] = cyc;
        swst[k] = sw;
      end
      if (cur[k] !== 1'b1 && prv[k]) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL pulse_unexpected kind=%0d start=%0d width=%0d required no pulse", k, st[k], cyc - st[k]);
        end else begin
          e = sb.pop_front();
          if (e.kind != k || e.start != st[k] || e.width != cyc - st[k] || swst[k] !== e.sw) begin
            fails++;
            $display("FAIL pulse kind/start/width/sw got %0d/%0d/%0d/%h required %0d/%0d/%0d/%h",
                     k, st[k], cyc - st[k], swst[k], e.kind, e.start, e.width, e.sw);
          end
        end
      end
    end
    prv = cur;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_pulse(input int kind, input int start, input int width, input logic [11:0] swv);
    pulse_t e;
    e.kind = kind;
    e.start = start;
    e.width = width;
    e.sw = swv;
    sb.push_back(e);
  endtask
  task automatic test_reset;
    rst = 1;
    sw_raw = 12'h123;
    tick(3);
    tests++;
    if ({sw, dep, incp, run, busy} !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h required 0", {sw, dep, incp, run, busy});
    end
    rst = 0;
    chk_en = 1;
    tick(6);
    tests++;
    if (sw !== 12'h123) begin
      fails++;
      $display("FAIL idle_sw_track got %h required 123", sw);
    end
    tests++;
    if ({dep, incp, run, busy} !== 4'b0) begin
      fails++;
      $display("FAIL idle_outputs got %b required 0000", {dep, incp, run, busy});
    end
  endtask
  task automatic test_deposit;
    int c;
    sw_raw = 12'hA5C;
    tick(4);
    dep_raw = 1;
    c = cyc;
    expect_pulse(0, c + 20, 2, 12'hA5C);
    if (AUTO) expect_pulse(1, c + 24, 2, 12'hA5C);
    tick(19);
    tests++;
    if (dep !== 1'b0) begin
      fails++;
      $display("FAIL dep_early got %b required 0", dep);
    end
    tick(1);
    tests++;
    if (dep !== 1'b1 || sw !== 12'hA5C) begin
      fails++;
      $display("FAIL dep_rise dep=%b sw=%h required 1/a5c", dep, sw);
    end
    sw_raw = 12'h3C3;
    tick(2);
    tests++;
    if (dep !== 1'b0 || busy !== 1'b1 || sw !== 12'hA5C) begin
      fails++;
      $display("FAIL dep_gap dep=%b busy=%b sw=%h required 0/1/a5c", dep, busy, sw);
    end
    tick(2);
    tests++;
    if (busy !== AUTO || incp !== AUTO || sw !== 12'hA5C) begin
      fails++;
      $display("FAIL after_gap busy=%b incp=%b sw=%h required %b/%b/a5c", busy, incp, sw, AUTO, AUTO);
    end
    tick(4);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL seq_end busy=%b required 0", busy);
    end
    tick(12);
    dep_raw = 0;
    tests++;
    if (sw !== 12'h3C3) begin
      fails++;
      $display("FAIL sw_reload got %h required 3c3", sw);
    end
    tick(30);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL deposit_pending got %0d required 0", sb.size());
    end
  endtask
  task automatic test_bounce;
    for (int i = 0; i < 12; i++) begin
      start_raw = ~start_raw;
      tick(5);
      tests++;
      if (run !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL bounce run=%b busy=%b required 0/0", run, busy);
      end
    end
    start_raw = 0;
    tick(30);
    tests++;
    if (run !== 1'b0) begin
      fails++;
      $display("FAIL bounce_end run=%b required 0", run);
    end
  endtask
  task automatic test_run_halt;
    start_raw = 1;
    tick(19);
    tests++;
    if (run !== 1'b0) begin
      fails++;
      $display("FAIL run_early got %b required 0", run);
    end
    tick(1);
    tests++;
    if (run !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL run_rise run=%b busy=%b required 1/0", run, busy);
    end
    tick(20);
    start_raw = 0;
    tick(30);
    halt = 1;
    tick(2);
    tests++;
    if (run !== 1'b1) begin
      fails++;
      $display("FAIL halt_early got %b required 1", run);
    end
    tick(1);
    tests++;
    if (run !== 1'b0) begin
      fails++;
      $display("FAIL halt_stop got %b required 0", run);
    end
    tick(5);
    start_raw = 1;
    tick(20);
    tests++;
    if (run !== 1'b1) begin
      fails++;
      $display("FAIL rerun got %b required 1", run);
    end
    tick(20);
    start_raw = 0;
    tick(40);
    tests++;
    if (run !== 1'b1) begin
      fails++;
      $display("FAIL halt_level_retrigger got %b required 1", run);
    end
    stop_raw = 1;
    tick(19);
    tests++;
    if (run !== 1'b1) begin
      fails++;
      $display("FAIL stop_early got %b required 1", run);
    end
    tick(1);
    tests++;
    if (run !== 1'b0) begin
      fails++;
      $display("FAIL stop got %b required 0", run);
    end
    tick(20);
    stop_raw = 0;
    halt = 0;
    tick(30);
  endtask
  task automatic test_simultaneous;
    start_raw = 1;
    dep_raw = 1;
    tick(20);
    tests++;
    if (run !== 1'b1 || dep !== 1'b0) begin
      fails++;
      $display("FAIL simul run=%b dep=%b required 1/0", run, dep);
    end
    tick(20);
    start_raw = 0;
    dep_raw = 0;
    tick(30);
    dep_raw = 1;
    incp_raw = 1;
    tick(40);
    dep_raw = 0;
    incp_raw = 0;
    tick(30);
    tests++;
    if (run !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL run_ignore run=%b busy=%b required 1/0", run, busy);
    end
    stop_raw = 1;
    tick(20);
    tests++;
    if (run !== 1'b0) begin
      fails++;
      $display("FAIL simul_stop got %b required 0", run);
    end
    stop_raw = 0;
    tick(30);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL simul_pending got %0d required 0", sb.size());
    end
  endtask
  task automatic test_reset_midpulse;
    int c;
    sw_raw = 12'h5A5;
    tick(4);
    dep_raw = 1;
    c = cyc;
    expect_pulse(0, c + 20, 1, 12'h5A5);
    tick(20);
    tests++;
    if (dep !== 1'b1) begin
      fails++;
      $display("FAIL mid_dep got %b required 1", dep);
    end
    rst = 1;
    tick(1);
    tests++;
    if ({sw, dep, incp, run, busy} !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset got %h required 0", {sw, dep, incp, run, busy});
    end
    tick(2);
    rst = 0;
    c = cyc;
    expect_pulse(0, c + 20, 2, 12'h5A5);
    if (AUTO) expect_pulse(1, c + 24, 2, 12'h5A5);
    tick(19);
    tests++;
    if (dep !== 1'b0) begin
      fails++;
      $display("FAIL held_early got %b required 0", dep);
    end
    tick(1);
    tests++;
    if (dep !== 1'b1) begin
      fails++;
      $display("FAIL held_press got %b required 1", dep);
    end
    tick(20);
    dep_raw = 0;
    tick(40);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL reset_pending got %0d required 0", sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_deposit();
    test_bounce();
    test_run_halt();
    test_simultaneous();
    test_reset_midpulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
